// File: rtl/flash_arb_pkg.sv
// rtl/flash_arb_pkg.sv - shared types, widths and byte-lane helper for the flash byte arbiter
package flash_arb_pkg;

    localparam int FLASH_AW = 23;
    localparam int BYTE_AW  = 25;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CAPTURE,
        RESP
    } arb_state_t;

    function automatic logic [7:0] lane_sel(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        b = word[{lane, 3'b000} +: 8];
        return b;
    endfunction

endpackage

// File: rtl/flash_byte_arbiter_cache.sv
// rtl/flash_byte_arbiter_cache.sv - one-entry flash word cache (flash_word_cache), used under FLASH_WORD_CACHE_EN
module flash_word_cache
    import flash_arb_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fill,
    input  logic [FLASH_AW-1:0] fill_tag,
    input  logic [31:0]         fill_word,
    input  logic [FLASH_AW-1:0] lookup_tag,
    output logic                hit,
    output logic [31:0]         word
);

    logic                valid;
    logic [FLASH_AW-1:0] tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            tag   <= '0;
            word  <= '0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= fill_tag;
            word  <= fill_word;
        end
    end

    assign hit = valid && (tag == lookup_tag);

endmodule

// File: rtl/flash_byte_arbiter.sv
// rtl/flash_byte_arbiter.sv - round-robin byte reader sharing one fixed-latency flash port; FLASH_WORD_CACHE_EN adds a one-word cache
module flash_byte_arbiter
    import flash_arb_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0,
    input  logic                req1,
    input  logic [BYTE_AW-1:0]  byte_addr0,
    input  logic [BYTE_AW-1:0]  byte_addr1,
    output logic                ack0,
    output logic                ack1,
    output logic [7:0]          data0,
    output logic [7:0]          data1,
    output logic [FLASH_AW-1:0] flash_address,
    output logic                flash_read,
    input  logic [31:0]         flash_q
);

    localparam int CW = $clog2(LATENCY + 1);

    arb_state_t         state, state_nxt;
    logic               grant;
    logic               last_grant;
    logic [1:0]         lane;
    logic [CW-1:0]      cnt;
    logic               any_req;
    logic               pick;
    logic [BYTE_AW-1:0] pick_addr;
    logic               cache_hit;
    logic [7:0]         hit_byte;

    // A tie goes to whichever requester was not served last
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~last_grant;
        end else if (req1) begin
            pick = 1'b1;
        end
    end

    assign any_req   = req0 | req1;
    assign pick_addr = pick ? byte_addr1 : byte_addr0;

`ifdef FLASH_WORD_CACHE_EN
    logic [31:0] cache_word;

    flash_word_cache u_cache (
        .clk        (clk),
        .rst_n      (rst_n),
        .fill       (state == CAPTURE),
        .fill_tag   (flash_address),
        .fill_word  (flash_q),
        .lookup_tag (pick_addr[BYTE_AW-1:2]),
        .hit        (cache_hit),
        .word       (cache_word)
    );

    assign hit_byte = lane_sel(cache_word, pick_addr[1:0]);
`else
    assign cache_hit = 1'b0;
    assign hit_byte  = 8'h00;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = cache_hit ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt <= CW'(1)) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ack0 = (state == RESP) && !grant;
        ack1 = (state == RESP) && grant;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant         <= 1'b0;
            last_grant    <= 1'b1;
            lane          <= 2'd0;
            cnt           <= '0;
            flash_address <= '0;
            flash_read    <= 1'b0;
            data0         <= 8'h00;
            data1         <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant         <= pick;
                        last_grant    <= pick;
                        lane          <= pick_addr[1:0];
                        flash_address <= pick_addr[BYTE_AW-1:2];
                        if (cache_hit) begin
                            if (pick) begin
                                data1 <= hit_byte;
                            end else begin
                                data0 <= hit_byte;
                            end
                        end else begin
                            cnt        <= CW'(LATENCY);
                            flash_read <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                end
                CAPTURE: begin
                    if (grant) begin
                        data1 <= lane_sel(flash_q, lane);
                    end else begin
                        data0 <= lane_sel(flash_q, lane);
                    end
                    flash_read <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_byte_arbiter.sv
// tb/tb_flash_byte_arbiter.sv - self-checking bench for flash_byte_arbiter (LATENCY 1 and 3 instances)
module tb_flash_byte_arbiter;

    localparam int LAT  = 1;
    localparam int LAT3 = 3;
`ifdef FLASH_WORD_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [24:0] a0, a1;
    logic        ack0, ack1;
    logic [7:0]  data0, data1;
    logic [22:0] fa;
    logic        fr;
    logic [31:0] fq;

    logic        r3;
    logic [24:0] a3;
    logic        ack3_0, ack3_1;
    logic [7:0]  d3_0, d3_1;
    logic [22:0] fa3;
    logic        fr3;
    logic [31:0] fq3, p0, p1;

    int total = 0;
    int bad   = 0;
    bit          mc_valid;
    logic [22:0] mc_tag;

    always #5 clk = ~clk;

    flash_byte_arbiter #(.LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .byte_addr0(a0), .byte_addr1(a1), .ack0(ack0), .ack1(ack1),
        .data0(data0), .data1(data1), .flash_address(fa), .flash_read(fr), .flash_q(fq)
    );

    flash_byte_arbiter #(.LATENCY(LAT3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req0(r3), .req1(1'b0),
        .byte_addr0(a3), .byte_addr1(25'd0), .ack0(ack3_0), .ack1(ack3_1),
        .data0(d3_0), .data1(d3_1), .flash_address(fa3), .flash_read(fr3), .flash_q(fq3)
    );

    function automatic logic [31:0] mem_word(input logic [22:0] w);
        case (w)
            23'd6:   return 32'h04030201;
            23'd7:   return 32'h08070605;
            23'd8:   return 32'h0C0B0A09;
            default: return 32'hAABBCCDD;
        endcase
    endfunction

    function automatic logic [7:0] exp_byte(input logic [24:0] addr);
        logic [31:0] w;
        w = mem_word(addr[24:2]) >> (8 * addr[1:0]);
        return w[7:0];
    endfunction

    // Expected request-to-ack cycles; tracks what a one-word cache would hold
    function int exp_lat(input logic [22:0] w);
        if (CACHE_EN && mc_valid && mc_tag == w) return 1;
        mc_valid = 1'b1;
        mc_tag   = w;
        return LAT + 2;
    endfunction

    // Flash models: q registered LATENCY edges after the address
    always @(posedge clk) fq <= mem_word(fa);
    always @(posedge clk) begin
        p0  <= mem_word(fa3);
        p1  <= p0;
        fq3 <= p1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output int n, output bit who, output bit got);
        n = 0; who = 1'b0; got = 1'b0;
        while (!got && n < 30) begin
            tick();
            n++;
            if (ack0 || ack1) begin
                got = 1'b1;
                who = ack1;
                chk("single_ack", {31'd0, ack0 & ack1}, 32'd0);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; r3 = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        mc_valid = 1'b0;
    endtask

    typedef struct {
        bit          r0;
        bit          r1;
        logic [24:0] ad0;
        logic [24:0] ad1;
        bit          who;
        logic [7:0]  data;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n, n2, el;
        bit  who, got;
        bit          pend[2];
        logic [24:0] radr[2];
        int          rwait[2];

        vecs[0] = '{1'b1, 1'b0, 25'd24, 25'd0,  1'b0, 8'h01};
        vecs[1] = '{1'b1, 1'b0, 25'd27, 25'd0,  1'b0, 8'h04};
        vecs[2] = '{1'b0, 1'b1, 25'd0,  25'd28, 1'b1, 8'h05};
        vecs[3] = '{1'b1, 1'b1, 25'd32, 25'd0,  1'b0, 8'h09};
        vecs[4] = '{1'b1, 1'b1, 25'd32, 25'd0,  1'b1, 8'hDD};
        vecs[5] = '{1'b1, 1'b1, 25'd33, 25'd2,  1'b0, 8'h0A};
        vecs[6] = '{1'b0, 1'b1, 25'd0,  25'd31, 1'b1, 8'h08};
        vecs[7] = '{1'b1, 1'b1, 25'd9,  25'd30, 1'b0, 8'hCC};
        vecs[8] = '{1'b1, 1'b0, 25'd26, 25'd0,  1'b0, 8'h03};

        a0 = '0; a1 = '0; a3 = '0;
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; r3 = 1'b0;
        tick(); tick();
        chk("rst_ack0", {31'd0, ack0}, 32'd0);
        chk("rst_ack1", {31'd0, ack1}, 32'd0);
        chk("rst_data0", {24'd0, data0}, 32'd0);
        chk("rst_data1", {24'd0, data1}, 32'd0);
        chk("rst_faddr", {9'd0, fa}, 32'd0);
        chk("rst_fread", {31'd0, fr}, 32'd0);
        rst_n = 1'b1;
        mc_valid = 1'b0;

        // Tie straight out of reset: requester 0 first, then alternate
        req0 = 1'b1; a0 = 25'd32; req1 = 1'b1; a1 = 25'd0;
        el = exp_lat(23'd8);
        wait_ack(n, who, got);
        chk("tie1_who", {31'd0, who}, 32'd0);
        chk("tie1_lat", n, el);
        chk("tie1_data", {24'd0, data0}, 32'h09);
        req0 = 1'b0;
        el = 1 + exp_lat(23'd0);
        wait_ack(n, who, got);
        chk("tie2_who", {31'd0, who}, 32'd1);
        chk("tie2_lat", n, el);
        chk("tie2_data", {24'd0, data1}, 32'hDD);
        chk("data0_held", {24'd0, data0}, 32'h09);
        req0 = 1'b1; a0 = 25'd36;
        el = 1 + exp_lat(23'd9);
        wait_ack(n, who, got);
        chk("tie3_who", {31'd0, who}, 32'd0);
        chk("tie3_lat", n, el);
        chk("tie3_data", {24'd0, data0}, 32'hDD);
        req0 = 1'b0;
        el = 1 + exp_lat(23'd0);
        wait_ack(n, who, got);
        chk("held_req1_who", {31'd0, who}, 32'd1);
        chk("held_req1_lat", n, el);
        req1 = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            req0 = vecs[i].r0; req1 = vecs[i].r1;
            a0 = vecs[i].ad0; a1 = vecs[i].ad1;
            el = exp_lat(vecs[i].who ? vecs[i].ad1[24:2] : vecs[i].ad0[24:2]);
            wait_ack(n, who, got);
            chk($sformatf("vec%0d_got", i), {31'd0, got}, 32'd1);
            chk($sformatf("vec%0d_who", i), {31'd0, who}, {31'd0, vecs[i].who});
            chk($sformatf("vec%0d_lat", i), n, el);
            chk($sformatf("vec%0d_data", i), {24'd0, vecs[i].who ? data1 : data0}, {24'd0, vecs[i].data});
            req0 = 1'b0; req1 = 1'b0;
            tick();
        end

        // Reset while the flash access is outstanding
        req0 = 1'b1; a0 = 25'd24;
        tick();
        chk("mid_fread_wait", {31'd0, fr}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_fread_rst", {31'd0, fr}, 32'd0);
        chk("mid_data0_rst", {24'd0, data0}, 32'd0);
        tick(); tick();
        chk("mid_no_ack", {31'd0, ack0}, 32'd0);
        rst_n = 1'b1;
        mc_valid = 1'b0;
        el = exp_lat(23'd6);
        wait_ack(n, who, got);
        chk("mid_after_lat", n, el);
        chk("mid_after_data", {24'd0, data0}, 32'h01);
        req0 = 1'b0;
        tick();

        // Random traffic: every ack must carry the addressed byte within a bounded wait
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (ack0 || ack1) chk("rnd_single_ack", {31'd0, ack0 & ack1}, 32'd0);
            for (int k = 0; k < 2; k++) begin
                if (k == 0 ? ack0 : ack1) begin
                    chk("rnd_pending", {31'd0, pend[k]}, 32'd1);
                    chk("rnd_data", {24'd0, k == 0 ? data0 : data1}, {24'd0, exp_byte(radr[k])});
                    chk("rnd_wait", {31'd0, rwait[k] < 2 * (LAT + 3) + 1}, 32'd1);
                    pend[k] = 1'b0;
                end else if (pend[k]) begin
                    rwait[k]++;
                end
                if (!pend[k] && c < 370 && $urandom_range(0, 2) == 0) begin
                    pend[k]  = 1'b1;
                    rwait[k] = 0;
                    radr[k]  = 25'($urandom_range(0, 47));
                end
            end
            req0 = pend[0]; req1 = pend[1];
            if (pend[0]) a0 = radr[0];
            if (pend[1]) a1 = radr[1];
        end
        for (int c = 0; c < 30 && (pend[0] || pend[1]); c++) begin
            tick();
            if (ack0) begin
                chk("drain_data0", {24'd0, data0}, {24'd0, exp_byte(radr[0])});
                pend[0] = 1'b0; req0 = 1'b0;
            end
            if (ack1) begin
                chk("drain_data1", {24'd0, data1}, {24'd0, exp_byte(radr[1])});
                pend[1] = 1'b0; req1 = 1'b0;
            end
        end
        chk("drain_done", {31'd0, pend[0] | pend[1]}, 32'd0);

        // Same-word reuse: served from the cache when it is built in
        do_reset();
        req0 = 1'b1; a0 = 25'd24;
        el = exp_lat(23'd6);
        wait_ack(n, who, got);
        chk("c1_lat", n, el);
        chk("c1_data", {24'd0, data0}, 32'h01);
        req0 = 1'b0;
        tick();
        req0 = 1'b1; a0 = 25'd25;
        el = exp_lat(23'd6);
        tick();
        chk("c2_fread_t1", {31'd0, fr}, {31'd0, !CACHE_EN});
        if (ack0) begin
            n = 1;
        end else begin
            wait_ack(n2, who, got);
            n = 1 + n2;
        end
        chk("c2_lat", n, el);
        chk("c2_data", {24'd0, data0}, 32'h02);
        chk("c2_fread_ack", {31'd0, fr}, 32'd0);
        req0 = 1'b0;
        tick();
        req0 = 1'b1; a0 = 25'd28;
        el = exp_lat(23'd7);
        wait_ack(n, who, got);
        chk("c3_lat", n, el);
        chk("c3_data", {24'd0, data0}, 32'h05);
        req0 = 1'b0;
        tick();

        // LATENCY=3 instance
        r3 = 1'b1; a3 = 25'd35;
        tick();
        n = 1;
        chk("l3_fread", {31'd0, fr3}, 32'd1);
        while (!ack3_0 && n < 30) begin
            tick();
            n++;
        end
        chk("l3_lat", n, LAT3 + 2);
        chk("l3_data", {24'd0, d3_0}, 32'h0C);
        chk("l3_no_ack1", {31'd0, ack3_1}, 32'd0);
        r3 = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
